// File: rtl/flipper_axi_burst_reader.sv
// AXI4 INCR read-burst initiator for Flipper AXI Interface A, with a first-word-fall-through beat buffer.
// Optional feature macro: FLIPPER_AXI_RD_ERR_ABORT_EN (stop issuing bursts after the first error response).
module flipper_axi_burst_reader #(
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_beats,
  output logic [31:0]      araddrm_a,
  output logic [1:0]       arburstm_a,
  output logic [3:0]       arlenm_a,
  output logic [2:0]       arsizem_a,
  output logic             arvalidm_a,
  input  logic             arreadym_a,
  input  logic [127:0]     rdatam_a,
  input  logic [1:0]       rrespm_a,
  input  logic             rlastm_a,
  input  logic             rvalidm_a,
  output logic             rreadym_a,
  output logic [127:0]     dout_data,
  output logic             dout_last,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [27:0]      addr_q, addr_d;          // byte address >> 4
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             arvalid_q, arvalid_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [3:0]       arlen_q, arlen_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [128:0]     mem [FIFO_DEPTH];        // {last, data}
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [128:0]     out_word_q, out_word_d;

  logic [8:0]       to_boundary;
  logic [4:0]       burst_len;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] free_space;
  logic             fifo_full;
  logic             rready;
  logic             r_push;
  logic             push_last;
  logic             pop;
  logic             ld_mem;
  logic             ld_byp;
  logic             wr_en;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[3:0];

  assign to_boundary = 9'd256 - {1'b0, addr_q[7:0]};

  always_comb begin
    burst_len = 5'd16;
    if (remaining_q < LEN_W'(16)) begin
      burst_len = 5'(remaining_q);
    end
    if ({4'b0, burst_len} > to_boundary) begin
      burst_len = 5'(to_boundary);
    end
  end

  assign fifo_count = mem_cnt_q + CNT_W'(out_valid_q);
  assign free_space = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign rready     = (state_q == ST_DATA) && !fifo_full;
  assign r_push     = rready && rvalidm_a;
  assign pop        = out_valid_q && dout_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    done_d      = 1'b0;
    err_d       = err_q;
    push_last   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr[31:4];
          remaining_d = req_beats;
          err_d       = 1'b0;
          if (req_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        // Space for the whole burst is reserved up front so R never back-pressures.
        if (!arvalid_q) begin
          if (free_space >= CNT_W'(burst_len)) begin
            arvalid_d = 1'b1;
            araddr_d  = {addr_q, 4'h0};
            arlen_d   = 4'(burst_len - 5'd1);
          end
        end else if (arreadym_a) begin
          arvalid_d   = 1'b0;
          addr_d      = addr_q + 28'(arlen_q) + 28'd1;
          remaining_d = remaining_q - LEN_W'(arlen_q) - LEN_W'(1);
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_push) begin
          if (rrespm_a != 2'b00) begin
            err_d = 1'b1;
`ifdef FLIPPER_AXI_RD_ERR_ABORT_EN
            remaining_d = '0;
`endif
          end
          push_last = (remaining_d == '0) && rlastm_a;
          if (rlastm_a) begin
            state_d = (remaining_d == '0) ? ST_DRAIN : ST_ADDR;
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q && (mem_cnt_q == '0)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register refills from the array first; an empty buffer lets the R beat bypass straight in.
  always_comb begin
    ld_mem = 1'b0;
    ld_byp = 1'b0;
    if (!out_valid_q || pop) begin
      if (mem_cnt_q != '0) begin
        ld_mem = 1'b1;
      end else if (r_push) begin
        ld_byp = 1'b1;
      end
    end
    wr_en       = r_push && !ld_byp;
    out_valid_d = (out_valid_q && !pop) || ld_mem || ld_byp;
    out_word_d  = out_word_q;
    if (ld_mem) begin
      out_word_d = mem[rd_ptr_q];
    end else if (ld_byp) begin
      out_word_d = {push_last, rdatam_a};
    end
    rd_ptr_d  = rd_ptr_q + PTR_W'(ld_mem);
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
    mem_cnt_d = mem_cnt_q + CNT_W'(wr_en) - CNT_W'(ld_mem);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {push_last, rdatam_a};
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign araddrm_a  = araddr_q;
  assign arburstm_a = 2'b01;
  assign arlenm_a   = arlen_q;
  assign arsizem_a  = 3'b100;
  assign arvalidm_a = arvalid_q;
  assign rreadym_a  = rready;
  assign dout_data  = out_word_q[127:0];
  assign dout_last  = out_word_q[128];
  assign dout_valid = out_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_flipper_axi_burst_reader.sv
// Scoreboard bench for flipper_axi_burst_reader: random AXI slave, request-level reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_flipper_axi_burst_reader;

  localparam int FIFO_DEPTH = 32;
  localparam int LEN_W      = 16;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = '0;
  logic [LEN_W-1:0] req_beats = '0;
  logic [31:0]      araddrm_a;
  logic [1:0]       arburstm_a;
  logic [3:0]       arlenm_a;
  logic [2:0]       arsizem_a;
  logic             arvalidm_a;
  logic             arreadym_a;
  logic [127:0]     rdatam_a;
  logic [1:0]       rrespm_a;
  logic             rlastm_a;
  logic             rvalidm_a;
  logic             rreadym_a;
  logic [127:0]     dout_data;
  logic             dout_last;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             done;
  logic             err;

  flipper_axi_burst_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_beats(req_beats),
    .araddrm_a(araddrm_a), .arburstm_a(arburstm_a), .arlenm_a(arlenm_a), .arsizem_a(arsizem_a),
    .arvalidm_a(arvalidm_a), .arreadym_a(arreadym_a),
    .rdatam_a(rdatam_a), .rrespm_a(rrespm_a), .rlastm_a(rlastm_a), .rvalidm_a(rvalidm_a),
    .rreadym_a(rreadym_a),
    .dout_data(dout_data), .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] d; logic l; } beat_t;
  typedef struct { logic [31:0] a; logic [3:0] l; } ar_t;

  beat_t exp_beat_q[$];
  ar_t   exp_ar_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    exp_done = 1'b0;
  logic  exp_err = 1'b0;
  int    done_cnt = 0;
  int    r_cnt = 0;
  int    pop_cnt = 0;
  int    ars_in_req = 0;
  int    err_idx = -1;
  int    sink_mode = 0;
  bit    timed_out = 1'b0;

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream sink ----------------
  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b0;
      endcase
    end
  end

  // ---------------- AXI read slave ----------------
  ar_t         sl_q[$];
  ar_t         sl_new;
  int          sl_idx = 0;
  int          sl_beat = 0;
  bit          s_ar_hs, s_r_hs, s_req_hs, s_last;
  logic [31:0] s_addr;
  logic [3:0]  s_len;

  initial begin
    arreadym_a = 1'b0;
    rvalidm_a  = 1'b0;
    rdatam_a   = '0;
    rrespm_a   = 2'b00;
    rlastm_a   = 1'b0;
    forever begin
      @(negedge clk);
      s_ar_hs  = arvalidm_a && arreadym_a;
      s_r_hs   = rvalidm_a && rreadym_a;
      s_req_hs = req_valid && req_ready;
      s_last   = rlastm_a;
      s_addr   = araddrm_a;
      s_len    = arlenm_a;
      @(posedge clk);
      #1;
      if (!resetn) begin
        sl_q.delete();
        sl_idx     = 0;
        sl_beat    = 0;
        rvalidm_a  = 1'b0;
        rlastm_a   = 1'b0;
        arreadym_a = 1'b0;
      end else begin
        if (s_req_hs) sl_beat = 0;
        if (s_r_hs) begin
          sl_beat++;
          sl_idx++;
          if (s_last) begin
            void'(sl_q.pop_front());
            sl_idx = 0;
          end
        end
        if (s_ar_hs) begin
          sl_new.a = s_addr;
          sl_new.l = s_len;
          sl_q.push_back(sl_new);
        end
        if (!rvalidm_a || s_r_hs) begin
          if (sl_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            rvalidm_a = 1'b1;
            rdatam_a  = data_of(sl_q[0].a + 32'(16 * sl_idx));
            rlastm_a  = (sl_idx == int'(sl_q[0].l));
            rrespm_a  = (sl_beat == err_idx) ? 2'b10 : 2'b00;
          end else begin
            rvalidm_a = 1'b0;
            rlastm_a  = 1'b0;
          end
        end
        arreadym_a = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit           prev_hold = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;
  bit           ar_pend = 1'b0;
  ar_t          ar_cur;
  ar_t          mon_ar;
  beat_t        mon_beat;
  bit           in_req = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_hold = 1'b0;
      ar_pend   = 1'b0;
      in_req    = 1'b0;
      r_cnt     = 0;
      pop_cnt   = 0;
    end else begin
      if (prev_hold) begin
        check("dout_hold_valid", 128'(dout_valid), 128'(1'b1));
        check("dout_hold_data", dout_data, prev_data);
        check("dout_hold_last", 128'(dout_last), 128'(prev_last));
      end
      prev_hold = dout_valid && !dout_ready;
      prev_data = dout_data;
      prev_last = dout_last;

      if (ar_pend) begin
        check("ar_stable_valid", 128'(arvalidm_a), 128'(1'b1));
        check("ar_stable_addr", 128'(araddrm_a), 128'(ar_cur.a));
        check("ar_stable_len", 128'(arlenm_a), 128'(ar_cur.l));
      end else if (arvalidm_a) begin
        ar_cur.a = araddrm_a;
        ar_cur.l = arlenm_a;
        ars_in_req++;
        check("ar_space", 128'((FIFO_DEPTH - (r_cnt - pop_cnt)) >= (int'(arlenm_a) + 1)), 128'(1'b1));
        if (exp_ar_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ar: got addr %h len %0d, required none", araddrm_a, arlenm_a);
        end else begin
          mon_ar = exp_ar_q.pop_front();
          check("ar_addr", 128'(araddrm_a), 128'(mon_ar.a));
          check("ar_len", 128'(arlenm_a), 128'(mon_ar.l));
        end
      end
      ar_pend = arvalidm_a && !arreadym_a;

      if (rvalidm_a && rreadym_a) r_cnt++;
      if (dout_valid && dout_ready) begin
        pop_cnt++;
        if (exp_beat_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, required none", dout_data);
        end else begin
          mon_beat = exp_beat_q.pop_front();
          check("dout_data", dout_data, mon_beat.d);
          check("dout_last", 128'(dout_last), 128'(mon_beat.l));
        end
      end

      if (done) begin
        in_req = 1'b0;
        check("done_expected", 128'(exp_done), 128'(1'b1));
        check("done_err", 128'(err), 128'(exp_err));
        check("done_beats_left", 128'(exp_beat_q.size()), 128'(0));
        check("done_ars_left", 128'(exp_ar_q.size()), 128'(0));
        exp_done = 1'b0;
        done_cnt++;
      end else if (in_req) begin
        check("busy", 128'(busy), 128'(1'b1));
      end
      if (req_valid && req_ready) begin
        ars_in_req = 0;
        in_req     = (req_beats != '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_req(input logic [31:0] a, input int nb, input int eidx, input int smode);
    beat_t       bq[$];
    beat_t       b;
    ar_t         ar;
    logic [31:0] cur;
    int          rem, len, tob, start;
    bit          stop;
    if (timed_out) return;
    for (int c = 0; c < 300 && !req_ready; c++) @(posedge clk);
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0, required 1");
      timed_out = 1'b1;
      return;
    end
    cur   = {a[31:4], 4'h0};
    rem   = nb;
    start = 0;
    stop  = 1'b0;
    while (rem > 0 && !stop) begin
      len = (rem < 16) ? rem : 16;
      tob = 256 - int'(cur[11:4]);
      if (tob < len) len = tob;
      ar.a = cur;
      ar.l = 4'(len - 1);
      exp_ar_q.push_back(ar);
      for (int j = 0; j < len; j++) begin
        b.d = data_of(cur + 32'(16 * j));
        b.l = 1'b0;
        bq.push_back(b);
      end
`ifdef FLIPPER_AXI_RD_ERR_ABORT_EN
      if (eidx >= start && eidx < start + len) stop = 1'b1;
`endif
      start += len;
      cur   += 32'(16 * len);
      rem   -= len;
    end
    if (bq.size() > 0) bq[bq.size() - 1].l = 1'b1;
    foreach (bq[i]) exp_beat_q.push_back(bq[i]);
    exp_err   = (eidx >= 0 && eidx < nb);
    exp_done  = 1'b1;
    err_idx   = eidx;
    sink_mode = smode;
    @(posedge clk);
    #1;
    req_addr  = a;
    req_beats = LEN_W'(nb);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] a, input int nb);
    int d0;
    if (timed_out) return;
    d0 = done_cnt;
    for (int c = 0; c < 4000 && done_cnt == d0; c++) @(posedge clk);
    if (done_cnt == d0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done, required done for addr %h beats %0d", a, nb);
      timed_out = 1'b1;
    end else begin
      $display("req addr=%h beats=%0d err_idx=%0d ars=%0d err=%0b", a, nb, err_idx, ars_in_req, err);
    end
  endtask

  task automatic run_req(input logic [31:0] a, input int nb, input int eidx, input int smode);
    issue_req(a, nb, eidx, smode);
    wait_done(a, nb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(1'b1));
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_done"}, 128'(done), 128'(1'b0));
    check({tag, "_err"}, 128'(err), 128'(1'b0));
    check({tag, "_arvalid"}, 128'(arvalidm_a), 128'(1'b0));
    check({tag, "_araddr"}, 128'(araddrm_a), 128'(0));
    check({tag, "_arlen"}, 128'(arlenm_a), 128'(0));
    check({tag, "_dout_valid"}, 128'(dout_valid), 128'(1'b0));
    check({tag, "_rready"}, 128'(rreadym_a), 128'(1'b0));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [31:0] ra;
    int rb, re;
    #12;
    check_reset_outputs("reset");
    check("arburst", 128'(arburstm_a), 128'(2'b01));
    check("arsize", 128'(arsizem_a), 128'(3'b100));
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;

    // single short burst plus AR latency
    issue_req(32'h0000_1000, 4, -1, 0);
    @(negedge clk);
    check("ar_latency_pre", 128'(arvalidm_a), 128'(1'b0));
    @(negedge clk);
    check("ar_latency", 128'(arvalidm_a), 128'(1'b1));
    check("ar_latency_addr", 128'(araddrm_a), 128'(32'h0000_1000));
    wait_done(32'h0000_1000, 4);

    run_req(32'h0000_0000, 40, -1, 1);
    run_req(32'h0000_0FC0, 8, -1, 1);

    // back-pressure: third burst must wait for buffer space
    issue_req(32'h0000_0000, 48, -1, 2);
    r0 = r_cnt;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("bp_ars_issued", 128'(ars_in_req), 128'(2));
    check("bp_arvalid_held", 128'(arvalidm_a), 128'(1'b0));
    check("bp_beats_buffered", 128'(r_cnt - r0), 128'(FIFO_DEPTH));
    sink_mode = 0;
    wait_done(32'h0000_0000, 48);

    // error response on beat 2
    run_req(32'h0000_0000, 40, 1, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("err_sticky", 128'(err), 128'(1'b1));

    // zero-length request clears err and issues nothing
    run_req(32'h0000_2340, 0, -1, 0);

    // reset in the middle of a data phase
    issue_req(32'h0000_0000, 40, -1, 0);
    r0 = r_cnt;
    for (int c = 0; c < 500 && (r_cnt - r0) < 5; c++) @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_beat_q.delete();
    exp_ar_q.delete();
    exp_done = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    run_req(32'h0000_3000, 20, -1, 1);

    // randomized requests
    for (int i = 0; i < 12; i++) begin
      ra = $urandom_range(0, 32'h000F_FFFF);
      if ($urandom_range(0, 2) == 0) ra = {ra[31:12], 8'hF0 + 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      rb = $urandom_range(0, 70);
      re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rb) : -1;
      run_req(ra, rb, re, $urandom_range(0, 1));
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
